// File: rtl/if_fetch.sv
// Instruction fetch: PC address -> ibus request, in-order responses buffered in an instruction FIFO for decode.
// Latency: rvalid to inst_valid_o is 1 cycle (0 cycles with IF_BYPASS_EN when the FIFO is empty).
// Backpressure: pc_stall_o holds the PC unless a request is granted; issue stops once FIFO + in-flight reach DEPTH.
//
// Ports:
//   clk, rstn                      clock and asynchronous active-low reset
//   pc_i                           fetch address; forwarded unchanged on ibus_addr_o
//   hold_en_i                      bit0 = redirect/flush, bit1 = decode stall, bits 4:2 unused
//   pc_stall_o                     PC must hold this cycle (combinational from ibus_gnt_i)
//   ibus_req_o/addr_o/gnt_i        instruction-bus request channel
//   ibus_rvalid_i/rdata_i          in-order response channel
//   inst_valid_o/inst_o/instaddr_o head instruction to decode (NOP_INST / 0 when invalid)
//   id_ready_i                     decode accepts the head entry
// Optional feature macro: IF_BYPASS_EN (same-cycle forwarding of a response into an empty FIFO).

module if_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc_i,
    input  logic [4:0]  hold_en_i,
    output logic        pc_stall_o,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] instaddr_o,
    input  logic        id_ready_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        RST   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] outstanding;   // all in-flight requests, live and discarded
    logic [CW-1:0] fifo_cnt;      // instruction FIFO occupancy
    logic [CW-1:0] discard_cnt;   // in-flight responses still belonging to a stale path
    logic [PW-1:0] a_wr;
    logic [PW-1:0] a_rd;
    logic [PW-1:0] i_wr;
    logic [PW-1:0] i_rd;

    // Address FIFO: one entry per live in-flight request, popped by its response.
    logic [31:0] addr_mem  [DEPTH];
    logic [31:0] imem_addr [DEPTH];
    logic [31:0] imem_data [DEPTH];

    logic          flush;
    logic          dec_stall;
    logic          issue;
    logic          rsp;
    logic          live;
    logic          byp_vld;
    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [CW:0]   occupancy;
    logic [CW-1:0] out_after_rsp;
    logic          unused_hold_bits;

    assign flush            = hold_en_i[0];
    assign dec_stall        = hold_en_i[1];
    assign unused_hold_bits = ^hold_en_i[4:2];

    // Capacity check deliberately ignores a same-cycle pop so the request does
    // not depend on id_ready_i.
    assign occupancy   = {1'b0, fifo_cnt} + {1'b0, outstanding};
    assign ibus_req_o  = (state != RST) && !flush && (occupancy < (CW+1)'(DEPTH));
    assign ibus_addr_o = pc_i;
    assign issue       = ibus_req_o && ibus_gnt_i;
    assign pc_stall_o  = !issue;

    // A response with nothing outstanding (e.g. a leftover across reset) is ignored.
    assign rsp           = ibus_rvalid_i && (outstanding != '0);
    assign live          = rsp && !flush && (discard_cnt == '0);
    assign out_after_rsp = outstanding - CW'(rsp);
    assign fifo_empty    = (fifo_cnt == '0);

`ifdef IF_BYPASS_EN
    assign byp_vld = fifo_empty && live;
`else
    assign byp_vld = 1'b0;
`endif

    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = NOP_INST;
        instaddr_o   = '0;
        if (!fifo_empty) begin
            inst_valid_o = 1'b1;
            inst_o       = imem_data[i_rd];
            instaddr_o   = imem_addr[i_rd];
        end else if (byp_vld) begin
            inst_valid_o = 1'b1;
            inst_o       = ibus_rdata_i;
            instaddr_o   = addr_mem[a_rd];
        end
    end

    // Flush takes priority over consumption: nothing is popped in a flush cycle.
    assign accept = inst_valid_o && id_ready_i && !dec_stall && !flush;
    assign pop    = accept && !fifo_empty;
    // A bypassed response that decode takes right away never enters the FIFO.
    assign push   = live && !(byp_vld && accept);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= RST;
            outstanding <= '0;
            fifo_cnt    <= '0;
            discard_cnt <= '0;
            a_wr        <= '0;
            a_rd        <= '0;
            i_wr        <= '0;
            i_rd        <= '0;
        end else if (flush) begin
            // Everything still in flight after this cycle belongs to the old path.
            outstanding <= out_after_rsp;
            discard_cnt <= out_after_rsp;
            fifo_cnt    <= '0;
            a_wr        <= '0;
            a_rd        <= '0;
            i_wr        <= '0;
            i_rd        <= '0;
            state       <= (out_after_rsp != '0) ? DRAIN : RUN;
        end else begin
            outstanding <= out_after_rsp + CW'(issue);
            fifo_cnt    <= fifo_cnt + CW'(push) - CW'(pop);
            if (issue) a_wr <= a_wr + PW'(1);
            if (live)  a_rd <= a_rd + PW'(1);
            if (push)  i_wr <= i_wr + PW'(1);
            if (pop)   i_rd <= i_rd + PW'(1);
            if (rsp && (discard_cnt != '0)) discard_cnt <= discard_cnt - CW'(1);
            case (state)
                RST:     state <= RUN;
                RUN:     state <= RUN;
                DRAIN:   if ((discard_cnt == '0) || (rsp && (discard_cnt == CW'(1)))) state <= RUN;
                default: state <= RST;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (issue) addr_mem[a_wr] <= pc_i;
        if (push) begin
            imem_addr[i_wr] <= addr_mem[a_rd];
            imem_data[i_wr] <= ibus_rdata_i;
        end
    end

endmodule
